// File: rtl/logic_unit_nbit.sv
// logic_unit_nbit: registered bitwise logic lane for the ALU datapath.
// Computes one of eight bitwise ops on A/B, attaches zero/ones/parity flags
// and queues the result in a DEPTH-entry output FIFO.
// Optional macro LOGIC_ROTATE_EN: op 111 becomes rotate-left of A by the low
// $clog2(WIDTH) bits of B instead of PASS A.
//
// Handshakes (both sides): a beat transfers on a rising edge where valid and
// ready are both high. in_ready = (level < DEPTH) comes from registered state
// only, never from out_ready, so a full FIFO refuses a push even when it pops
// on the same edge. out_valid = (level != 0); a push into an empty FIFO is
// visible on the output one cycle later, so there is no in->out comb path.
module logic_unit_nbit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic [2:0]               op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         Y,
  output logic                     zero,
  output logic                     ones,
  output logic                     parity,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              op_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = WIDTH + 3;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
  // Held output after reset: Y=0 so zero=1, ones=0, parity=0.
  localparam logic [ENT_W-1:0] HOLD_RST = {1'b0, 1'b0, 1'b1, {WIDTH{1'b0}}};

  // Entry layout: [WIDTH-1:0]=Y, [WIDTH]=zero, [WIDTH+1]=ones, [WIDTH+2]=parity
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [15:0]      count_q, count_d;
  logic [ENT_W-1:0] hold_q, hold_d;

  logic [WIDTH-1:0] res;
  logic [ENT_W-1:0] ent;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] out_sel;
  logic             push;
  logic             pop;

`ifdef LOGIC_ROTATE_EN
  logic [$clog2(WIDTH)-1:0] rot_amt;
  logic [2*WIDTH-1:0]       rot_full;
  assign rot_amt  = B[$clog2(WIDTH)-1:0];
  // Shifting the doubled word left leaves the rotated value in the top half;
  // amount 0 yields A unchanged.
  assign rot_full = {A, A} << rot_amt;
`endif

  // Operation decode
  always_comb begin
    res = A;
    case (op)
      3'b000:  res = ~A;
      3'b001:  res = A & B;
      3'b010:  res = A | B;
      3'b011:  res = A ^ B;
      3'b100:  res = ~(A & B);
      3'b101:  res = ~(A | B);
      3'b110:  res = ~(A ^ B);
`ifdef LOGIC_ROTATE_EN
      3'b111:  res = rot_full[2*WIDTH-1:WIDTH];
`else
      3'b111:  res = A;
`endif
      default: res = A;
    endcase
  end

  assign ent       = {^res, &res, ~|res, res};
  assign in_ready  = ~rst & (level_q < DEPTH_LVL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_sel   = out_valid ? head : hold_q;

  assign Y        = out_sel[WIDTH-1:0];
  assign zero     = out_sel[WIDTH];
  assign ones     = out_sel[WIDTH+1];
  assign parity   = out_sel[WIDTH+2];
  assign level    = level_q;
  assign op_count = count_q;

  // Next-state for pointers, occupancy, op counter and held output
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = count_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      hold_d   = head;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
      hold_q   <= HOLD_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // FIFO storage; contents are meaningless once level returns to 0
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ent;
  end

endmodule

// File: tb/tb_logic_unit_nbit.sv
// Bench for logic_unit_nbit (WIDTH=16, DEPTH=4).
module tb_logic_unit_nbit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Y;
  logic        zero;
  logic        ones;
  logic        parity;
  logic [2:0]  level;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];

  logic_unit_nbit #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .zero(zero), .ones(ones), .parity(parity),
    .level(level), .op_count(op_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: {parity, ones, zero, Y}
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] o);
    logic [15:0] r;
    int amt;
    case (o)
      3'd0: r = ~a;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = ~(a ^ b);
      default: begin
`ifdef LOGIC_ROTATE_EN
        amt = int'(b[3:0]);
        r = (amt == 0) ? a : ((a << amt) | (a >> (16 - amt)));
`else
        amt = 0;
        r = a;
`endif
      end
    endcase
    return {^r, (r == 16'hFFFF), (r == 16'h0000), r};
  endfunction

  // driver: present one op for exactly one accepting edge (called at posedge+1 with in_ready=1)
  task automatic apply_one(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
    A = a; B = b; op = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'bx;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || level !== 3'd0 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b level=%0d op_count=%0d, want 0 0 0 0",
               in_ready, out_valid, level, op_count);
    end
    checks++;
    if (Y !== 16'h0000 || zero !== 1'b1 || ones !== 1'b0 || parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: Y=%h zero=%b ones=%b parity=%b, want 0000 1 0 0", Y, zero, ones, parity);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_not_sweep();
    logic [15:0] a_t [4];
    logic [15:0] y_t [4];
    logic [2:0]  f_t [4];  // {parity, ones, zero}
    a_t = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555};
    y_t = '{16'hFFFF, 16'h0000, 16'h5555, 16'hAAAA};
    f_t = '{3'b010, 3'b001, 3'b000, 3'b000};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_one(a_t[i], 16'h1234, 3'b000);
      checks++;
      if (out_valid !== 1'b1 || Y !== y_t[i] || {parity, ones, zero} !== f_t[i]) begin
        errors++;
        $display("FAIL not_sweep[%0d]: valid=%b Y=%h flags=%b, want 1 %h %b",
                 i, out_valid, Y, {parity, ones, zero}, y_t[i], f_t[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (op_count !== 16'd4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL not_count: op_count=%0d out_valid=%b, want 4 0", op_count, out_valid);
    end
  endtask

  task automatic test_binary_ops();
    logic [15:0] y_t [6];
    y_t = '{16'hC0C0, 16'hFCFC, 16'h3C3C, 16'h3F3F, 16'h0303, 16'hC3C3};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_one(16'hF0F0, 16'hCCCC, 3'(i + 1));
      checks++;
      if (out_valid !== 1'b1 || Y !== y_t[i]) begin
        errors++;
        $display("FAIL binop[%0d]: valid=%b Y=%h, want 1 %h", i + 1, out_valid, Y, y_t[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (op_count !== 16'd10) begin
      errors++;
      $display("FAIL binop_count: op_count=%0d, want 10", op_count);
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic acc;
    logic [15:0] bp_a [5];
    bp_a = '{16'h0001, 16'h0203, 16'h0405, 16'h0607, 16'h0809};
    out_ready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 8 && k < 4; cyc++) begin
      A = bp_a[k]; B = 16'h00FF; op = 3'(k % 7); in_valid = 1'b1;
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    A = bp_a[4]; B = 16'h0F0F; op = 3'b011;
    checks++;
    if (k !== 4 || in_ready !== 1'b0 || level !== 3'd4) begin
      errors++;
      $display("FAIL bp_full: accepted=%0d in_ready=%b level=%0d, want 4 0 4", k, in_ready, level);
    end
    @(posedge clk); #1;
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL bp_hold: level=%0d, want 4", level);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_one_pop: level=%0d in_ready=%b, want 3 1", level, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL bp_refill: level=%0d, want 4", level);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && level != 3'd0; cyc++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (level !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: level=%0d pending=%0d, want 0 0", level, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      A = 16'($urandom_range(0, 16'hFFFF));
      B = 16'($urandom_range(0, 16'hFFFF));
      op = 3'($urandom_range(0, 7));
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (level !== 3'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d]: level=%0d in_ready=%b, want 1 1", i, level, in_ready);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (level !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_end: level=%0d pending=%0d, want 0 0", level, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) apply_one(16'(16'h1111 * (i + 1)), 16'h0F0F, 3'(i + 1));
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL mid_pre: level=%0d, want 3", level);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b0 || op_count !== 16'd0 ||
        Y !== 16'h0000 || zero !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%b level=%0d in_ready=%b count=%0d Y=%h zero=%b, want 0 0 0 0 0000 1",
               out_valid, level, in_ready, op_count, Y, zero);
    end
    exp_q.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== 3'd0 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_release: in_ready=%b valid=%b level=%0d count=%0d, want 1 0 0 0",
               in_ready, out_valid, level, op_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale[%0d]: out_valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_rotate();
    logic [15:0] exp_a;
`ifdef LOGIC_ROTATE_EN
    exp_a = 16'h0018;
`else
    exp_a = 16'h8001;
`endif
    out_ready = 1'b1;
    apply_one(16'h8001, 16'h0004, 3'b111);
    checks++;
    if (out_valid !== 1'b1 || Y !== exp_a || parity !== 1'b0) begin
      errors++;
      $display("FAIL rot_4: valid=%b Y=%h parity=%b, want 1 %h 0", out_valid, Y, parity, exp_a);
    end
    @(posedge clk); #1;
    apply_one(16'h8001, 16'h0010, 3'b111);
    checks++;
    if (out_valid !== 1'b1 || Y !== 16'h8001) begin
      errors++;
      $display("FAIL rot_0: valid=%b Y=%h, want 1 8001", out_valid, Y);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1; A = '0; B = '0; op = '0;
    // scoreboard: push on accepting edge, pop/compare on popping edge
    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: unexpected output Y=%h", Y);
          end else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            if ({parity, ones, zero, Y} !== e) begin
              errors++;
              $display("FAIL sb_data: got p/o/z/Y=%b%b%b/%h, want %b%b%b/%h",
                       parity, ones, zero, Y, e[18], e[17], e[16], e[15:0]);
            end
          end
        end
        if (!rst && in_valid && in_ready) exp_q.push_back(model(A, B, op));
      end
    join_none

    test_reset();
    test_not_sweep();
    test_binary_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_rotate();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_nbit.md
Name: logic_unit_nbit

Overview:
- Parametrised, registered successor to the fixed 16-bit inverter.
- Computes one of eight bitwise operations on two WIDTH-bit operands and attaches result flags.
- Results are buffered in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Sits in the ALU datapath as the logic-op lane beside the adder and shifter lanes.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/op present
in_ready  output  1  unit can accept this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B (ignored for NOT/PASS)
op  input  3  operation select
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
Y  output  WIDTH  result at FIFO head
zero  output  1  Y == 0
ones  output  1  Y == all ones
parity  output  1  XOR-reduction of Y
level  output  $clog2(DEPTH)+1  current FIFO occupancy
op_count  output  16  total accepted operations, wraps

Behaviour:
- Op encoding: 000 NOT A; 001 A AND B; 010 A OR B; 011 A XOR B; 100 NAND; 101 NOR; 110 XNOR; 111 PASS A.
- Accept: a transaction is taken on a rising edge with in_valid && in_ready. The result and its three flags are computed combinationally and written into the FIFO on that same edge.
- Latency: with an empty FIFO, out_valid rises in the cycle after accept (1-cycle latency). No combinational in->out path.
- Pop: happens on an edge with out_valid && out_ready; the head then advances.
- Y/flags while out_valid=0: hold the last popped values (0 after reset). Checkers must ignore them.
- in_ready = (level < DEPTH). It depends only on registered state, never on out_ready. When full, a same-cycle pop does not admit a push.
- Simultaneous push and pop when 0 < level < DEPTH: level is unchanged and both pointers advance.
- Push into an empty FIFO with out_ready=1: the pop cannot happen that cycle because out_valid is still 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level saturates at neither end; overflow and underflow are prevented by the handshake.
- op_count increments by 1 per accepted transaction and wraps 0xFFFF -> 0x0000.
- Reset (asserted at any time, including with a full FIFO or mid-handshake) clears immediately:
  - in_ready=0 while rst=1, then 1 in the first cycle after release.
  - out_valid=0, Y=0, zero=1, ones=0, parity=0, level=0, op_count=0, pointers=0.
  - FIFO contents are discarded.
- An X on op while in_valid=0 is ignored. With in_valid=1, op must be known.

Optional Feature:
Macro LOGIC_ROTATE_EN.
- Defined: op 111 becomes rotate-left of A by B[$clog2(WIDTH)-1:0] (amount 0 = PASS A). Upper bits of B are ignored. Flags are computed on the rotated result.
- Undefined: op 111 is PASS A. No rotate logic is synthesised. Everything else is identical.

Test Plan (WIDTH=16, DEPTH=4):
- Reset then NOT sweep: A=0000,FFFF,AAAA,5555 with op=000 and out_ready=1 -> Y=FFFF,0000,5555,AAAA in order, each 1 cycle after accept. Flags: ones=1, zero=1, then parity=0 for the last two. op_count=4.
- All binary ops: A=F0F0, B=CCCC, op 001..110 -> Y=C0C0, FCFC, 3C3C, 3F3F, 0303, C3C3.
- Backpressure: out_ready=0 and push 5 ops -> in_ready drops after the 4th accept and level=4. Set out_ready=1 for one cycle -> level=3, in_ready=1 next cycle. Order is preserved, no loss or duplication.
- Steady stream: in_valid=1 and out_ready=1 continuously for 20 ops -> level stays at 1 after the first accept, one result per cycle. Wrap of all pointers is checked against a scoreboard.
- Reset mid-operation: with level=3, pulse rst between clock edges -> out_valid=0 and level=0 immediately. No stale data appears after release. op_count=0.
- LOGIC_ROTATE_EN: A=8001, B=0004, op=111 -> Y=0018, parity=0. B=0010 -> Y=8001 (amount 0). Without the macro, the same stimulus gives Y=8001 for both.
